// File: rtl/byte_ram_arbiter.sv
// Round-robin arbiter sharing one synchronous byte-wide RAM between the
// instruction-fetch port and the load/store data port.
module byte_ram_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int WAIT_STATES   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
  output logic                     fetch_busy,
  output logic [7:0]               fetch_data,
  input  logic                     data_req,
  input  logic                     data_we,
  input  logic [ADDRESS_WIDTH-1:0] data_addr,
  input  logic [7:0]               data_wdata,
  output logic                     data_busy,
  output logic [7:0]               data_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {PORT_NONE, PORT_FETCH, PORT_DATA} port_t;

  state_t                     state_q, state_d;
  port_t                      active_q, active_d;
  port_t                      last_grant_q, last_grant_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic                       f_pend_q, f_pend_d;
  logic                       d_pend_q, d_pend_d;
  logic [ADDRESS_WIDTH-1:0]   f_addr_q, f_addr_d;
  logic [ADDRESS_WIDTH-1:0]   d_addr_q, d_addr_d;
  logic                       d_we_q, d_we_d;
  logic [7:0]                 d_wdata_q, d_wdata_d;
  logic                       mem_en_q, mem_en_d;
  logic                       mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]                 mem_wdata_q, mem_wdata_d;
  logic [7:0]                 fetch_data_q, fetch_data_d;
  logic [7:0]                 data_rdata_q, data_rdata_d;
  logic                       f_cand, d_cand;
  port_t                      grant;

  assign f_cand     = fetch_req | f_pend_q;
  assign d_cand     = data_req | d_pend_q;
  assign fetch_busy = fetch_req | f_pend_q | (active_q == PORT_FETCH);
  assign data_busy  = data_req | d_pend_q | (active_q == PORT_DATA);
  assign fetch_data = fetch_data_q;
  assign data_rdata = data_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    f_pend_d     = f_pend_q;
    d_pend_d     = d_pend_q;
    f_addr_d     = f_addr_q;
    d_addr_d     = d_addr_q;
    d_we_d       = d_we_q;
    d_wdata_d    = d_wdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
    grant        = PORT_NONE;

    if (fetch_req && !f_pend_q && active_q != PORT_FETCH) begin
      f_pend_d = 1'b1;
      f_addr_d = fetch_addr;
    end
    if (data_req && !d_pend_q && active_q != PORT_DATA) begin
      d_pend_d  = 1'b1;
      d_addr_d  = data_addr;
      d_we_d    = data_we;
      d_wdata_d = data_wdata;
    end

    case (state_q)
      IDLE: begin
        if (f_cand || d_cand) begin
          if (f_cand && d_cand)
            grant = (last_grant_q == PORT_DATA) ? PORT_FETCH : PORT_DATA;
          else
            grant = f_cand ? PORT_FETCH : PORT_DATA;
          if (grant == PORT_FETCH) begin
            mem_addr_d  = f_pend_q ? f_addr_q : fetch_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
            f_pend_d    = 1'b0;
          end else begin
            mem_addr_d  = d_pend_q ? d_addr_q : data_addr;
            mem_we_d    = d_pend_q ? d_we_q : data_we;
            mem_wdata_d = d_pend_q ? d_wdata_q : data_wdata;
            d_pend_d    = 1'b0;
          end
          mem_en_d     = 1'b1;
          cnt_d        = 5'(WAIT_STATES + 1);
          active_d     = grant;
          last_grant_d = grant;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // Counter holds through the strobe cycle, so it reaches 1 exactly
        // when read data is valid, WAIT_STATES+1 cycles after mem_en.
        if (!mem_en_q) begin
          if (cnt_q == 5'd1) begin
            if (active_q == PORT_FETCH)
              fetch_data_d = mem_rdata;
            else if (!d_we_q)
              data_rdata_d = mem_rdata;
            active_d = PORT_NONE;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      active_q     <= PORT_NONE;
      last_grant_q <= PORT_DATA;
      cnt_q        <= '0;
      f_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
      f_addr_q     <= '0;
      d_addr_q     <= '0;
      d_we_q       <= 1'b0;
      d_wdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      f_pend_q     <= f_pend_d;
      d_pend_q     <= d_pend_d;
      f_addr_q     <= f_addr_d;
      d_addr_q     <= d_addr_d;
      d_we_q       <= d_we_d;
      d_wdata_q    <= d_wdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule
